// File: rtl/uart_rx_block.sv
// 8N1 serial receiver: two-flop line synchronizer, mid-bit sampling FSM and a
// single-byte holding register read through the CONTROL/STATUS command codes.
module uart_rx_block #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] NOP          = 8'd0,
  parameter logic [7:0] ACK          = 8'd255,
  parameter logic [7:0] EMPTY        = 8'd0,
  parameter logic [7:0] VALID        = 8'd255,
  parameter logic [7:0] FERR         = 8'd127,
  parameter logic [7:0] OVR          = 8'd63
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_LINE,
  input  logic [7:0] CONTROL,
  output logic [7:0] DATA,
  output logic [7:0] STATUS
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF   = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state;
  state_t            state_n;
  logic              rx_p0;
  logic              rx_p1;
  logic              rx_s;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        idx;
  logic [DATA_W-1:0] shift;
  logic              cnt_clr;
  logic              idx_clr;
  logic              bit_smp;
  logic              vld_p2;
  logic [7:0]        ctrl_cmd;
  logic              ack;

  // A byte landing on an unread one is flagged as overrun unless software
  // acknowledges in the very same cycle; a bad stop bit outranks both.
  function automatic logic [7:0] commit_status(input logic       stop_bit,
                                               input logic [7:0] held,
                                               input logic       ack_now);
    if (!stop_bit) begin
      return FERR;
    end
    if ((held != EMPTY) && !ack_now) begin
      return OVR;
    end
    return VALID;
  endfunction

  // Anything other than ACK is treated as NOP.
  always_comb begin
    ctrl_cmd = (CONTROL == ACK) ? ACK : NOP;
    ack      = (ctrl_cmd == ACK);
  end

  // ---- stage p0/p1: metastability synchronizer, idles high ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= RX_LINE;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  // ---- stage p2: frame FSM, bit-period counter and byte assembly ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_clr = 1'b0;
    idx_clr = 1'b0;
    bit_smp = 1'b0;
    vld_p2  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) begin
          state_n = S_START;
        end
      end
      S_START: begin
        // Half a bit in: still low means a real start bit, high means a glitch.
        if (cnt == HALF_LAST) begin
          cnt_clr = 1'b1;
          if (!rx_s) begin
            state_n = S_DATA;
            idx_clr = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_clr = 1'b1;
          bit_smp = 1'b1;
          if (idx == 3'd7) begin
            state_n = S_STOP;
          end
        end
      end
      S_STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed.
        if (cnt == BIT_LAST) begin
          cnt_clr = 1'b1;
          vld_p2  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : (cnt + CNT_W'(1));
      if (idx_clr) begin
        idx <= '0;
      end else if (bit_smp) begin
        idx <= idx + 3'd1;
      end
      if (bit_smp) begin
        shift[idx] <= rx_s;
      end
    end
  end

  // ---- output: holding register seen by the CPU ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      DATA   <= '0;
      STATUS <= EMPTY;
    end else if (vld_p2) begin
      DATA   <= shift;
      STATUS <= commit_status(rx_s, STATUS, ack);
    end else if (ack) begin
      STATUS <= EMPTY;
    end
  end

endmodule

// File: tb/tb_uart_rx_block.sv
// Scoreboarded bench for uart_rx_block: directed scenarios plus random 8N1
// frames, with expected register transitions predicted from the frame rules.
module tb_uart_rx_block;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 3 + HALF + 9 * CPB;

  localparam logic [7:0] ACK_C   = 8'd255;
  localparam logic [7:0] NOP_C   = 8'd0;
  localparam logic [7:0] EMPTY_C = 8'd0;
  localparam logic [7:0] VALID_C = 8'd255;
  localparam logic [7:0] FERR_C  = 8'd127;
  localparam logic [7:0] OVR_C   = 8'd63;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_LINE = 1'b1;
  logic [7:0] CONTROL = 8'd0;
  logic [7:0] DATA;
  logic [7:0] STATUS;

  uart_rx_block #(.CLKS_PER_BIT(CPB)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .RX_LINE(RX_LINE),
    .CONTROL(CONTROL),
    .DATA   (DATA),
    .STATUS (STATUS)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] st;
    logic [7:0] d;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_st = EMPTY_C;
  logic [7:0] m_d  = 8'd0;
  bit         mon_en = 1'b0;
  bit         quiet  = 1'b0;
  int         n_chk  = 0;
  int         n_fail = 0;

  // Monitor: every visible change of {STATUS,DATA} must match the next
  // predicted transition, within one cycle of its predicted time.
  initial begin
    exp_t        e;
    logic [15:0] prev;
    logic [15:0] exp_cur;
    bit          rst_done;
    rst_done = 1'b0;
    prev     = 16'h0;
    exp_cur  = 16'h0;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (!rst_done) begin
          rst_done = 1'b1;
          n_chk++;
          if ({STATUS, DATA} !== {EMPTY_C, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state: got STATUS=%0d DATA=0x%02h, expected STATUS=%0d DATA=0x00",
                     STATUS, DATA, EMPTY_C);
          end
          prev = {STATUS, DATA};
        end else if ({STATUS, DATA} != prev) begin
          prev = {STATUS, DATA};
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_change at cycle %0d: got STATUS=%0d DATA=0x%02h, expected STATUS=%0d DATA=0x%02h",
                     cyc, STATUS, DATA, exp_cur[15:8], exp_cur[7:0]);
          end else begin
            e = exp_q.pop_front();
            exp_cur = {e.st, e.d};
            if ({STATUS, DATA} != {e.st, e.d}) begin
              n_fail++;
              $display("FAIL output at cycle %0d: got STATUS=%0d DATA=0x%02h, expected STATUS=%0d DATA=0x%02h",
                       cyc, STATUS, DATA, e.st, e.d);
            end
            n_chk++;
            if (cyc < e.due - 1 || cyc > e.due + 1) begin
              n_fail++;
              $display("FAIL latency: update at cycle %0d, expected cycle %0d (+/-1)", cyc, e.due);
            end
          end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].due + 1) begin
          e = exp_q.pop_front();
          exp_cur = {e.st, e.d};
          n_chk++;
          n_fail++;
          $display("FAIL timeout at cycle %0d: outputs still STATUS=%0d DATA=0x%02h, expected STATUS=%0d DATA=0x%02h by cycle %0d",
                   cyc, STATUS, DATA, e.st, e.d, e.due + 1);
        end else if (quiet && exp_q.size() == 0) begin
          n_chk++;
          if ({STATUS, DATA} != exp_cur) begin
            n_fail++;
            $display("FAIL quiet_hold at cycle %0d: got STATUS=%0d DATA=0x%02h, expected STATUS=%0d DATA=0x%02h",
                     cyc, STATUS, DATA, exp_cur[15:8], exp_cur[7:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    RX_LINE = 1'b1;
    repeat (n) tick();
  endtask

  // Reference model: the held register only changes when the prediction differs.
  function automatic void expect_out(input logic [7:0] st, input logic [7:0] d, input int due);
    exp_t e;
    if (st != m_st || d != m_d) begin
      e.st  = st;
      e.d   = d;
      e.due = due;
      exp_q.push_back(e);
    end
    m_st = st;
    m_d  = d;
  endfunction

  task automatic send_ack();
    expect_out(EMPTY_C, m_d, cyc + 1);
    CONTROL = ACK_C;
    tick();
    CONTROL = NOP_C;
  endtask

  // Drives one 8N1 frame. ack_commit raises ACK in the byte's commit cycle;
  // abort_bit >= 0 pulses RST partway through that data bit instead.
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit ack_commit,
                            input int abort_bit);
    int         t0;
    int         c;
    int         k;
    logic [7:0] st;
    t0 = cyc;
    c  = t0 + LAT;
    if (abort_bit < 0) begin
      if (!stop) st = FERR_C;
      else if (m_st != EMPTY_C && !ack_commit) st = OVR_C;
      else st = VALID_C;
      expect_out(st, b, c);
    end
    for (int i = 0; i < 10 * CPB; i++) begin
      k = i / CPB;
      if (abort_bit >= 0 && i == (1 + abort_bit) * CPB + 2) begin
        RX_LINE = 1'b1;
        CONTROL = NOP_C;
        RST     = 1'b1;
        expect_out(EMPTY_C, 8'h00, cyc + 1);
        tick();
        RST = 1'b0;
        return;
      end
      if (k == 0) RX_LINE = 1'b0;
      else if (k == 9) RX_LINE = stop;
      else RX_LINE = b[k-1];
      CONTROL = (ack_commit && (cyc + 1 == c)) ? ACK_C : NOP_C;
      tick();
    end
    RX_LINE = 1'b1;
    CONTROL = NOP_C;
  endtask

  initial begin
    logic [7:0] rb;
    bit         rstop;
    bit         rackc;
    bit         b2b;
    bit         prev_stop;

    RST = 1'b1;
    RX_LINE = 1'b1;
    CONTROL = NOP_C;
    repeat (4) tick();
    RST = 1'b0;
    mon_en = 1'b1;
    idle(5);

    // Good frame, then ACK clears STATUS but keeps DATA.
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    idle(16);
    send_ack();
    idle(8);

    // Framing error, ACK, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    idle(20);
    send_ack();
    idle(4);
    send_frame(8'h01, 1'b1, 1'b0, -1);
    idle(16);
    send_ack();
    idle(8);

    // Short glitch and ACK while empty: nothing may change.
    RX_LINE = 1'b0;
    tick();
    tick();
    RX_LINE = 1'b1;
    quiet = 1'b1;
    idle(4);
    send_ack();
    idle(16);
    quiet = 1'b0;
    send_frame(8'h55, 1'b1, 1'b0, -1);
    idle(16);
    send_ack();
    idle(8);

    // Back-to-back frames: overrun, then ACK on the second commit.
    send_frame(8'h11, 1'b1, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b0, -1);
    idle(16);
    send_ack();
    idle(8);
    send_frame(8'h11, 1'b1, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b1, -1);
    idle(16);

    // Reset during data bit 4, then recovery.
    send_frame(8'hF0, 1'b1, 1'b0, 4);
    idle(30);
    send_frame(8'h0F, 1'b1, 1'b0, -1);
    idle(16);
    send_ack();
    idle(8);

    // Transmitter-style traffic at matching bit period, ACK after each.
    send_frame(8'h00, 1'b1, 1'b0, -1);
    idle(12);
    send_ack();
    idle(4);
    send_frame(8'hFF, 1'b1, 1'b0, -1);
    idle(12);
    send_ack();
    idle(4);
    send_frame(8'h80, 1'b1, 1'b0, -1);
    idle(12);
    send_ack();
    idle(8);

    // Random traffic.
    prev_stop = 1'b1;
    for (int n = 0; n < 30; n++) begin
      rb    = 8'($urandom);
      rstop = ($urandom % 5) != 0;
      rackc = ($urandom % 4) == 0;
      b2b   = prev_stop && (($urandom % 3) == 0);
      if (!b2b) begin
        idle(16 + int'($urandom % 8));
        if (($urandom % 2) != 0) begin
          send_ack();
          idle(2);
        end
      end
      send_frame(rb, rstop, rackc, -1);
      prev_stop = rstop;
    end

    for (int w = 0; w < 300 && exp_q.size() != 0; w++) tick();
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d predictions outstanding", exp_q.size());
    $fatal(1, "watchdog expired");
  end

endmodule
